rapcore_wb_spi_master: RTL

Wishbone slave that lets the management SoC command the on-chip rapcore motor controller through rapcore's SPI target port (SCK/CS/COPI/CIPO), with no external wiring. The block sits upstream of rapcore in the user-project wrapper. It accepts 64-bit command words through memory-mapped registers, shifts them out in SPI mode 0, and captures the 64-bit reply. It shares the wishbone clock with rapcore, so SCK is a divided, registered strobe.

---
 rtl/rapcore_wb_spi_master.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rapcore_wb_spi_master.sv
// Wishbone-mapped SPI mode-0 master that drives rapcore's SPI target port.
// Each transfer sends TX[63:0] MSB first and captures the 64-bit reply into RX.
module rapcore_wb_spi_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [7:0]  DEFAULT_DIV = 8'd3,
  parameter int          XFER_BITS   = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        spi_sck_o,
  output logic        spi_cs_no,
  output logic        spi_copi_o,
  input  logic        spi_cipo_i,
  output logic        irq_o
);

  generate
    if (XFER_BITS != 64) begin : g_xfer_bits_check
      $error("rapcore_wb_spi_master: XFER_BITS must be 64");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP
  } state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [63:0] tx_q, tx_d;
  logic [63:0] rx_q, rx_d;
  logic [63:0] shift_tx_q, shift_tx_d;
  logic [63:0] rx_shift_q, rx_shift_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [6:0]  bcnt_q, bcnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        start_q, start_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        copi_q, copi_d;

  logic        req_valid;
  logic        accept;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  offset;
  logic        hp_done;
  logic        locked;
  logic [31:0] rd_val;
  logic        unused_adr;

  assign req_valid  = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  // Ack is held low for a cycle after each pulse, so a held strobe is taken once.
  assign accept     = req_valid && !ack_q;
  assign wr_en      = accept && wbs_we_i;
  assign rd_en      = accept && !wbs_we_i;
  assign offset     = wbs_adr_i[4:2];
  assign hp_done    = (hcnt_q == div_q);
  assign locked     = busy_q || start_q;
  assign unused_adr = ^wbs_adr_i[1:0];

  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_val = 32'h0;
    case (offset)
      3'd0:    rd_val = tx_q[31:0];
      3'd1:    rd_val = tx_q[63:32];
      3'd2:    rd_val = rx_q[31:0];
      3'd3:    rd_val = rx_q[63:32];
      3'd4:    rd_val = {16'h0, div_q, 8'h0};
      3'd5:    rd_val = {29'h0, ovr_q, done_q, busy_q};
      default: rd_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = accept;
    dat_d      = 32'h0;
    tx_d       = tx_q;
    rx_d       = rx_q;
    shift_tx_d = shift_tx_q;
    rx_shift_d = rx_shift_q;
    div_d      = div_q;
    hcnt_d     = hcnt_q;
    bcnt_d     = bcnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    start_d    = start_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    copi_d     = copi_q;

    if (rd_en) begin
      dat_d = rd_val;
      if (offset == 3'd3) done_d = 1'b0;
    end

    if (wr_en) begin
      case (offset)
        3'd0: begin
          if (locked) ovr_d = 1'b1;
          else        tx_d[31:0] = apply_sel(tx_q[31:0], wbs_dat_i, wbs_sel_i);
        end
        3'd1: begin
          if (locked) ovr_d = 1'b1;
          else        tx_d[63:32] = apply_sel(tx_q[63:32], wbs_dat_i, wbs_sel_i);
        end
        3'd4: begin
          // Clears land before START so one write can clear and relaunch.
          if (wbs_sel_i[0]) begin
            if (wbs_dat_i[1]) done_d = 1'b0;
            if (wbs_dat_i[2]) ovr_d  = 1'b0;
            if (wbs_dat_i[0]) begin
              if (locked) begin
                ovr_d = 1'b1;
              end else begin
                start_d = 1'b1;
                done_d  = 1'b0;
              end
            end
          end
          if (wbs_sel_i[1]) begin
            if (locked) ovr_d = 1'b1;
            else        div_d = wbs_dat_i[15:8];
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          start_d    = 1'b0;
          shift_tx_d = tx_q;
          cs_n_d     = 1'b0;
          sck_d      = 1'b0;
          copi_d     = tx_q[63];
          busy_d     = 1'b1;
          hcnt_d     = 8'd0;
          bcnt_d     = 7'd0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (hp_done) begin
          hcnt_d  = 8'd0;
          state_d = ST_SHIFT;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (hp_done) begin
          hcnt_d = 8'd0;
          if (!sck_q) begin
            sck_d      = 1'b1;
            rx_shift_d = {rx_shift_q[62:0], spi_cipo_i};
          end else begin
            sck_d  = 1'b0;
            bcnt_d = bcnt_q + 7'd1;
            // Last falling edge leaves COPI on bit 0 rather than shifting further.
            if (bcnt_q == 7'(XFER_BITS - 1)) begin
              state_d = ST_HOLD;
            end else begin
              shift_tx_d = {shift_tx_q[62:0], 1'b0};
              copi_d     = shift_tx_q[62];
            end
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (hp_done) begin
          hcnt_d  = 8'd0;
          rx_d    = rx_shift_q;
          cs_n_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (hp_done) begin
          hcnt_d  = 8'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          copi_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      tx_q       <= 64'h0;
      rx_q       <= 64'h0;
      shift_tx_q <= 64'h0;
      rx_shift_q <= 64'h0;
      div_q      <= DEFAULT_DIV;
      hcnt_q     <= 8'd0;
      bcnt_q     <= 7'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      start_q    <= 1'b0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      copi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      shift_tx_q <= shift_tx_d;
      rx_shift_q <= rx_shift_d;
      div_q      <= div_d;
      hcnt_q     <= hcnt_d;
      bcnt_q     <= bcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      start_q    <= start_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      copi_q     <= copi_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign spi_sck_o  = sck_q;
  assign spi_cs_no  = cs_n_q;
  assign spi_copi_o = copi_q;
  assign irq_o      = done_q;

endmodule
